// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank: prescaled 64-bit MMIO timebase with NUM_CMP auto-reloading compare channels
module mmio_timer_bank #(
  parameter int NUM_CMP = 2,
  parameter int PRESCALE_W = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0080_0008
) (
  input  logic clk,
  input  logic reset,
  input  logic ce,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic memwrite,
  output logic [31:0] dataout,
  output logic busy,
  output logic valid,
  output logic load_access_fault,
  output logic [NUM_CMP-1:0] intr_timer,
  output logic intr_any
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE, FAULT} state_t;
  state_t state;
  logic [7:0] off_q;
  logic [31:0] data_q;
  logic we_q;
  logic [63:0] mtime;
  logic [31:0] shadow;
  logic ctrl_en;
  logic [PRESCALE_W-1:0] prescale, pcnt;
  logic [NUM_CMP-1:0] pend, irq_en, pend_next, match;
  logic [63:0] cmp [NUM_CMP];
  logic [31:0] period [NUM_CMP];
  logic [31:0] off, rdata, ctrl_word;
  logic legal, tick, wr, rd, wr_mlo, wr_mhi, wr_ctrl, wr_pend, wr_en;
  assign off = addr - BASE_ADDR;
  assign wr = state == ACCESS && we_q;
  assign rd = state == ACCESS && !we_q;
  assign wr_mlo = wr && off_q == 8'h00;
  assign wr_mhi = wr && off_q == 8'h04;
  assign wr_ctrl = wr && off_q == 8'h08;
  assign wr_pend = wr && off_q == 8'h0C;
  assign wr_en = wr && off_q == 8'h10;
  assign tick = ctrl_en && pcnt == prescale;
  assign ctrl_word = (32'(prescale) << 8) | {31'd0, ctrl_en};
  assign intr_any = |intr_timer;
  // address legality: in window, word aligned, a defined global register or an existing channel slot
  always_comb begin
    legal = 1'b0;
    if (off[31:8] == '0 && off[1:0] == 2'b00 && addr[1:0] == 2'b00) begin
      legal = off[7:0] <= 8'h10;
      for (int i = 0; i < NUM_CMP; i++) if (off[7:4] == 4'(i + 2) && off[3:2] != 2'b11) legal = 1'b1;
    end
  end
  // match detect and sticky pending; a fresh match beats a same-cycle W1C
  always_comb begin
    for (int i = 0; i < NUM_CMP; i++) match[i] = mtime >= cmp[i];
    pend_next = match | (pend & ~(wr_pend ? data_q[NUM_CMP-1:0] : '0));
  end
  // read mux over the latched offset
  always_comb begin
    rdata = off_q == 8'h00 ? mtime[31:0] : off_q == 8'h04 ? shadow : off_q == 8'h08 ? ctrl_word :
            off_q == 8'h0C ? 32'(pend) : off_q == 8'h10 ? 32'(irq_en) : '0;
    for (int i = 0; i < NUM_CMP; i++) begin
      if (off_q == 8'(32 + 16 * i)) rdata = cmp[i][31:0];
      if (off_q == 8'(36 + 16 * i)) rdata = cmp[i][63:32];
      if (off_q == 8'(40 + 16 * i)) rdata = period[i];
    end
  end
  // bus handshake FSM; ce high returns to IDLE from any state
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      off_q <= '0;
      data_q <= '0;
      we_q <= 1'b0;
      dataout <= '0;
      busy <= 1'b0;
      valid <= 1'b0;
      load_access_fault <= 1'b0;
    end else if (ce) begin
      state <= IDLE;
      busy <= 1'b0;
      valid <= 1'b0;
      load_access_fault <= 1'b0;
    end else
      case (state)
        IDLE: begin
          off_q <= off[7:0];
          data_q <= datain;
          we_q <= memwrite;
          state <= legal ? ACCESS : FAULT;
          busy <= legal;
          load_access_fault <= !legal;
        end
        ACCESS: begin
          state <= DONE;
          busy <= 1'b0;
          valid <= !we_q;
          if (!we_q) dataout <= rdata;
        end
        default: ;
      endcase
  // timebase, prescaler, channels and interrupts; software writes override ticks and reloads
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      mtime <= '0;
      shadow <= '0;
      ctrl_en <= 1'b1;
      prescale <= '0;
      pcnt <= '0;
      pend <= '0;
      irq_en <= '0;
      intr_timer <= '0;
      for (int i = 0; i < NUM_CMP; i++) begin
        cmp[i] <= '1;
        period[i] <= '0;
      end
    end else begin
      pcnt <= wr_ctrl ? '0 : !ctrl_en ? pcnt : tick ? '0 : pcnt + 1'b1;
      if (wr_ctrl) begin
        ctrl_en <= data_q[0];
        prescale <= data_q[8 +: PRESCALE_W];
      end
      if (wr_mlo) mtime[31:0] <= data_q;
      else if (wr_mhi) mtime[63:32] <= data_q;
      else if (tick) mtime <= mtime + 64'd1;
      if (rd && off_q == 8'h00) shadow <= mtime[63:32];
      if (wr_en) irq_en <= data_q[NUM_CMP-1:0];
      pend <= pend_next;
      intr_timer <= pend_next & (wr_en ? data_q[NUM_CMP-1:0] : irq_en);
      for (int i = 0; i < NUM_CMP; i++) begin
        if (wr && off_q == 8'(32 + 16 * i)) cmp[i][31:0] <= data_q;
        else if (wr && off_q == 8'(36 + 16 * i)) cmp[i][63:32] <= data_q;
        else if (match[i] && period[i] != '0) cmp[i] <= cmp[i] + {32'd0, period[i]};
        if (wr && off_q == 8'(40 + 16 * i)) period[i] <= data_q;
      end
    end
endmodule

// File: tb/tb_mmio_timer_bank.sv
// tb_mmio_timer_bank: directed checks of bus timing, timebase, prescaler, compare channels and faults
module tb_mmio_timer_bank;
  localparam logic [31:0] BASE = 32'h0080_0008;
  logic clk = 1'b0, reset = 1'b0, ce = 1'b1, memwrite = 1'b0;
  logic [31:0] addr = '0, datain = '0, dataout;
  logic busy, valid, load_access_fault, intr_any;
  logic [1:0] intr_timer;
  logic b1, b2, v2, f1, f2, seen;
  logic [31:0] q;
  int tests = 0, fails = 0, cyc = 0, e0 = 0;
  mmio_timer_bank dut (
    .clk(clk), .reset(reset), .ce(ce), .addr(addr), .datain(datain), .memwrite(memwrite),
    .dataout(dataout), .busy(busy), .valid(valid), .load_access_fault(load_access_fault),
    .intr_timer(intr_timer), .intr_any(intr_any)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic acc_a(input logic we, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ce = 1'b0;
    addr = a;
    datain = d;
    memwrite = we;
    @(negedge clk);
    b1 = busy;
    f1 = load_access_fault;
    @(negedge clk);
    b2 = busy;
    v2 = valid;
    f2 = load_access_fault;
    q = dataout;
    ce = 1'b1;
  endtask
  task automatic acc(input logic we, input logic [7:0] off, input logic [31:0] d);
    acc_a(we, BASE + 32'(off), d);
  endtask
  task automatic wait_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_valid", valid, 0);
    check("rst_fault", load_access_fault, 0);
    check("rst_dataout", dataout, 0);
    check("rst_intr", intr_any, 0);
    reset = 1'b1;
    acc(0, 8'h00, 0);
    check("rd_busy_k1", b1, 1);
    check("rd_busy_k2", b2, 0);
    check("rd_valid", v2, 1);
    check("mtime_after_reset", q, 2);
    seen = 1'b0;
    repeat (1000) begin
      @(negedge clk);
      seen |= intr_any;
    end
    check("no_irq_1000", seen, 0);
    acc(0, 8'h08, 0);
    check("ctrl_reset", q, 1);
    acc(0, 8'h20, 0);
    check("cmp0_lo_reset", q, 32'hFFFF_FFFF);
    acc(0, 8'h24, 0);
    check("cmp0_hi_reset", q, 32'hFFFF_FFFF);
    acc(0, 8'h28, 0);
    check("period0_reset", q, 0);
    acc(1, 8'h00, 32'hFFFF_FFFE);
    check("wr_busy", b1, 1);
    check("wr_no_valid", v2, 0);
    acc(0, 8'h00, 0);
    check("lo_after_wrap", q, 0);
    acc(0, 8'h04, 0);
    check("hi_shadow_wrap", q, 1);
    acc(1, 8'h08, 0);
    acc(1, 8'h04, 5);
    acc(1, 8'h00, 7);
    acc(0, 8'h00, 0);
    check("lo_frozen", q, 7);
    acc(1, 8'h04, 9);
    acc(0, 8'h04, 0);
    check("hi_is_shadow", q, 5);
    acc(1, 8'h04, 0);
    acc(1, 8'h00, 0);
    acc(1, 8'h08, 32'h301);
    e0 = cyc;
    wait_to(e0 + 9);
    acc(0, 8'h00, 0);
    check("ps3_first", q, 2);
    acc(0, 8'h00, 0);
    check("ps3_second", q, 3);
    acc(1, 8'h08, 32'h301);
    e0 = cyc;
    wait_to(e0 + 1);
    acc(0, 8'h00, 0);
    check("ps3_restart_a", q, 4);
    acc(0, 8'h00, 0);
    check("ps3_restart_b", q, 5);
    acc(0, 8'h08, 0);
    check("ctrl_rb", q, 32'h301);
    acc(1, 8'h08, 0);
    acc(1, 8'h04, 0);
    acc(1, 8'h00, 90);
    acc(1, 8'h20, 100);
    acc(1, 8'h24, 0);
    acc(1, 8'h28, 50);
    acc(1, 8'h10, 1);
    acc(0, 8'h10, 0);
    check("irq_en_rb", q, 1);
    acc(1, 8'h08, 1);
    e0 = cyc;
    wait_to(e0 + 10);
    check("intr0_before_100", intr_timer, 0);
    wait_to(e0 + 11);
    check("intr0_at_100", intr_timer, 1);
    check("intr_any_at_100", intr_any, 1);
    acc(1, 8'h0C, 1);
    acc(0, 8'h0C, 0);
    check("pend_cleared", q, 0);
    check("intr_cleared", intr_any, 0);
    wait_to(e0 + 60);
    check("intr0_before_150", intr_any, 0);
    wait_to(e0 + 61);
    check("intr0_at_150", intr_timer, 1);
    acc(0, 8'h20, 0);
    check("cmp0_reload", q, 200);
    acc(1, 8'h30, 10);
    acc(1, 8'h34, 0);
    acc(1, 8'h0C, 3);
    acc(0, 8'h0C, 0);
    check("pend1_set_wins", q, 2);
    check("intr1_masked", intr_timer, 0);
    acc(0, 8'h30, 0);
    check("cmp1_no_reload", q, 10);
    acc(1, 8'h2C, 32'hDEAD);
    check("hole_fault", f1, 1);
    check("hole_fault_held", f2, 1);
    check("hole_no_busy", b1 | b2, 0);
    acc(1, 8'h01, 32'h55);
    check("misalign_fault", f1, 1);
    acc(1, 8'h40, 32'h1234);
    check("ch2_fault", f1, 1);
    acc(0, 8'h14, 0);
    check("gap_fault", f1, 1);
    acc_a(0, BASE + 32'h100, 0);
    check("above_fault", f1, 1);
    acc_a(0, BASE - 32'd4, 0);
    check("below_fault", f1, 1);
    acc(0, 8'h30, 0);
    check("legal_after_fault", f1, 0);
    check("valid_after_fault", v2, 1);
    check("cmp1_untouched", q, 10);
    acc(0, 8'h28, 0);
    check("period0_rb", q, 50);
    @(negedge clk);
    ce = 1'b0;
    addr = BASE + 32'h20;
    datain = 5;
    memwrite = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    ce = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    acc(0, 8'h20, 0);
    check("abort_no_write", q, 32'hFFFF_FFFF);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
